// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - single-channel memory-to-memory DMA bus master; DMA_TIMEOUT_EN adds per-access timeout
module dma_engine #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        dma_req,
    input  logic        dma_grant,
    inout  wire  [31:0] addr_bus,
    inout  wire  [31:0] data_bus,
    inout  wire         rd_bus,
    inout  wire         wr_bus,
    inout  wire  [3:0]  data_mask_bus,
    input  logic        fc_bus
);

    if (BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT < 1) begin : g_bad_param
        $error("dma_engine: BURST_LEN must be 1..255 and TIMEOUT at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_READ, S_RGAP, S_WRITE, S_WGAP, S_REL, S_DONE
    } state_t;

    state_t      state, state_n;
    logic [31:0] src_q, dst_q, buf_q;
    logic [15:0] cnt_q;
    logic [7:0]  burst_q;
    logic        rd_q, wr_q;
    logic        bus_state, drive, tmo_hit;

    assign bus_state = (state == S_READ) || (state == S_RGAP) ||
                       (state == S_WRITE) || (state == S_WGAP);
    // Losing the grant must release the bus combinationally, not a cycle later.
    assign drive     = dma_grant && bus_state;

`ifdef DMA_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign tmo_hit = ((state == S_READ) || (state == S_WRITE)) && !fc_bus &&
                     (tmo_q == TMO_W'(TIMEOUT - 1));
    assign err     = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = (word_count == 16'd0) ? S_DONE : S_REQ;
            S_REQ:   if (dma_grant) state_n = S_READ;
            S_READ: begin
                if (!dma_grant)   state_n = S_REQ;
                else if (tmo_hit) state_n = S_DONE;
                else if (fc_bus)  state_n = S_RGAP;
            end
            S_RGAP:  state_n = dma_grant ? S_WRITE : S_REQ;
            S_WRITE: begin
                if (!dma_grant)   state_n = S_REQ;
                else if (tmo_hit) state_n = S_DONE;
                else if (fc_bus)  state_n = S_WGAP;
            end
            S_WGAP: begin
                // The last word is already written, so completion needs no bus.
                if (cnt_q == 16'd0)                  state_n = S_DONE;
                else if (!dma_grant)                 state_n = S_REQ;
                else if (burst_q == 8'(BURST_LEN))   state_n = S_REL;
                else                                 state_n = S_READ;
            end
            S_REL:   state_n = S_REQ;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dma_req <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
`ifdef DMA_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            busy    <= (state_n != S_IDLE);
            done    <= (state_n == S_DONE);
            dma_req <= (state_n == S_REQ) || (state_n == S_READ) || (state_n == S_RGAP) ||
                       (state_n == S_WRITE) || (state_n == S_WGAP);
            rd_q    <= (state_n == S_READ);
            wr_q    <= (state_n == S_WRITE);

            if (state == S_IDLE && start) begin
                src_q   <= src_addr;
                dst_q   <= dst_addr;
                cnt_q   <= word_count;
                burst_q <= '0;
            end
            if (state == S_READ && dma_grant && fc_bus)
                buf_q <= data_bus;
            if (state == S_WRITE && dma_grant && fc_bus) begin
                src_q   <= src_q + 32'd4;
                dst_q   <= dst_q + 32'd4;
                cnt_q   <= cnt_q - 16'd1;
                burst_q <= burst_q + 8'd1;
            end
            // A new tenure starts after REL or after the grant was taken away.
            if (state == S_REL || (bus_state && state_n == S_REQ))
                burst_q <= '0;

`ifdef DMA_TIMEOUT_EN
            if (state_n == state && (state == S_READ || state == S_WRITE))
                tmo_q <= tmo_q + 1'b1;
            else
                tmo_q <= '0;
            if (state == S_IDLE && start)
                err_q <= 1'b0;
            else if (tmo_hit && dma_grant)
                err_q <= 1'b1;
`endif
        end
    end

    assign addr_bus      = drive ? ((state == S_WRITE || state == S_WGAP) ? dst_q : src_q) : 32'bz;
    assign data_bus      = (drive && wr_q) ? buf_q : 32'bz;
    assign rd_bus        = drive ? rd_q : 1'bz;
    assign wr_bus        = drive ? wr_q : 1'bz;
    assign data_mask_bus = drive ? 4'b1111 : 4'bzzzz;

endmodule
